// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-side bus of the PC sequencer: the instruction-memory request/ack pair
// plus the tagged instruction delivery stream.
interface pc_fetch_sequencer_if #(
    parameter int PC_WIDTH    = 7,
    parameter int INSTR_WIDTH = 16
);
    // fetch_req/fetch_addr are held stable until imem_ack is seen while fetch_req=1;
    // instr_valid is a one-cycle pulse qualifying instr_out/pc_out, with no backpressure.
    logic                   fetch_req;
    logic [PC_WIDTH-1:0]    fetch_addr;
    logic                   imem_ack;
    logic [INSTR_WIDTH-1:0] imem_data;
    logic                   instr_valid;
    logic [INSTR_WIDTH-1:0] instr_out;
    logic [PC_WIDTH-1:0]    pc_out;

    modport master (
        output fetch_req, fetch_addr, instr_valid, instr_out, pc_out,
        input  imem_ack, imem_data
    );

    modport slave (
        input  fetch_req, fetch_addr, instr_valid, instr_out, pc_out,
        output imem_ack, imem_data
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program-counter sequencer: owns the PC, issues fetches over req/ack and
// delivers returned instructions tagged with their PC; redirects squash in-flight fetches.
module pc_fetch_sequencer #(
    parameter int                PC_WIDTH    = 7,
    parameter int                INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                halt,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    pc_fetch_sequencer_if.master bus,
    output logic                halted,
    output logic [1:0]          fsm_state
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]             state;
    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    pend_tgt;
    logic                   squash;
    logic                   valid_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [PC_WIDTH-1:0]    pc_out_q;

    logic                   redir;
    logic [PC_WIDTH-1:0]    redir_tgt;
    logic                   ack;

    assign redir     = jump | branch_taken;
    assign redir_tgt = jump ? jump_target : branch_target;
    assign ack       = (state == ST_REQ) & bus.imem_ack;

    assign bus.fetch_req   = (state == ST_REQ);
    assign bus.fetch_addr  = pc;
    assign bus.instr_valid = valid_q;
    assign bus.instr_out   = instr_q;
    assign bus.pc_out      = pc_out_q;
    assign halted          = (state == ST_HALTED);
    assign fsm_state       = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            pc       <= RESET_PC;
            pend_tgt <= '0;
            squash   <= 1'b0;
            valid_q  <= 1'b0;
            instr_q  <= '0;
            pc_out_q <= RESET_PC;
        end else begin
            valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (redir) pc <= redir_tgt;
                    if (halt)        state <= ST_HALTED;
                    else if (!stall) state <= ST_REQ;
                end
                ST_REQ: begin
                    if (ack) begin
                        squash <= 1'b0;
                        // A redirect in the ack cycle is newer than any captured target.
                        if (redir) begin
                            pc <= redir_tgt;
                        end else if (squash) begin
                            pc <= pend_tgt;
                        end else begin
                            pc       <= pc + PC_WIDTH'(1);
                            valid_q  <= 1'b1;
                            instr_q  <= bus.imem_data;
                            pc_out_q <= pc;
                        end
                        if (halt)       state <= ST_HALTED;
                        else if (stall) state <= ST_IDLE;
                        else            state <= ST_REQ;
                    end else if (redir) begin
                        // Address must stay stable until ack, so park the target.
                        squash   <= 1'b1;
                        pend_tgt <= redir_tgt;
                    end
                end
                ST_HALTED: begin
                    state <= ST_HALTED;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: hand-computed fetch addresses and
// delivered instructions, memory returns addr*3.
module tb_pc_fetch_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       stall, halt, branch_taken, jump;
    logic [6:0] branch_target, jump_target;
    logic       halted;
    logic [1:0] fsm_state;

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] exp_q[$];

    pc_fetch_sequencer_if #(.PC_WIDTH(7), .INSTR_WIDTH(16)) bus ();

    assign bus.imem_data = 16'(bus.fetch_addr) * 16'd3;

    pc_fetch_sequencer #(.PC_WIDTH(7), .INSTR_WIDTH(16), .RESET_PC(7'd0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .halt(halt),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .bus(bus), .halted(halted), .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirect();
        jump = 1'b0; branch_taken = 1'b0;
        jump_target = '0; branch_target = '0;
    endtask

    // One-cycle jump accepted in the same cycle as an ack: no delivery, next request at tgt.
    task automatic jump_to(input logic [6:0] tgt, input string tag);
        jump = 1'b1; jump_target = tgt; bus.imem_ack = 1'b1;
        tick();
        clear_redirect();
        check({tag, "_addr"}, 32'(bus.fetch_addr), 32'(tgt));
        check({tag, "_novalid"}, 32'(bus.instr_valid), 32'd0);
    endtask

    task automatic expect_deliver(input string tag, input logic [6:0] pc);
        check({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
        check({tag, "_pc"}, 32'(bus.pc_out), 32'(pc));
        check({tag, "_instr"}, 32'(bus.instr_out), 32'(pc) * 32'd3);
    endtask

    initial begin
        logic [31:0] e;
        rst = 1'b1; stall = 1'b0; halt = 1'b0;
        clear_redirect();
        bus.imem_ack = 1'b0;
        tick(); tick();

        // reset state
        check("rst_req", 32'(bus.fetch_req), 32'd0);
        check("rst_addr", 32'(bus.fetch_addr), 32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_instr", 32'(bus.instr_out), 32'd0);
        check("rst_pcout", 32'(bus.pc_out), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);

        // streaming with zero-wait memory
        rst = 1'b0; bus.imem_ack = 1'b1;
        tick();
        check("s_req", 32'(bus.fetch_req), 32'd1);
        check("s_addr0", 32'(bus.fetch_addr), 32'd0);
        check("s_valid0", 32'(bus.instr_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("s_addr", 32'(bus.fetch_addr), 32'(k + 1));
            expect_deliver("s", 7'(k));
        end

        // wrap 127 -> 0
        jump_to(7'd125, "w_jump");
        exp_q.push_back(32'd125); exp_q.push_back(32'd126); exp_q.push_back(32'd127);
        exp_q.push_back(32'd0);   exp_q.push_back(32'd1);
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            expect_deliver("w", 7'(e));
            check("w_addr", 32'(bus.fetch_addr), (e + 32'd1) % 32'd128);
        end

        // 3-cycle ack latency at pc=4
        jump_to(7'd4, "d_jump");
        bus.imem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("d_hold_addr", 32'(bus.fetch_addr), 32'd4);
            check("d_hold_req", 32'(bus.fetch_req), 32'd1);
            check("d_hold_valid", 32'(bus.instr_valid), 32'd0);
        end
        bus.imem_ack = 1'b1;
        tick();
        expect_deliver("d", 7'd4);
        check("d_next_addr", 32'(bus.fetch_addr), 32'd5);

        // redirect while request outstanding at pc=8
        jump_to(7'd8, "b_jump");
        bus.imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 7'd40;
        tick();
        clear_redirect();
        check("b_hold_addr", 32'(bus.fetch_addr), 32'd8);
        tick();
        check("b_hold_addr2", 32'(bus.fetch_addr), 32'd8);
        bus.imem_ack = 1'b1;
        tick();
        check("b_squash_valid", 32'(bus.instr_valid), 32'd0);
        check("b_tgt_addr", 32'(bus.fetch_addr), 32'd40);
        // newer redirect overwrites parked one; jump beats branch
        bus.imem_ack = 1'b0; branch_taken = 1'b1; branch_target = 7'd50;
        tick();
        branch_target = 7'd40; jump = 1'b1; jump_target = 7'd20;
        tick();
        clear_redirect();
        check("p_hold_addr", 32'(bus.fetch_addr), 32'd40);
        bus.imem_ack = 1'b1;
        tick();
        check("p_squash_valid", 32'(bus.instr_valid), 32'd0);
        check("p_tgt_addr", 32'(bus.fetch_addr), 32'd20);
        tick();
        expect_deliver("p", 7'd20);
        check("p_next_addr", 32'(bus.fetch_addr), 32'd21);

        // stall during outstanding request at pc=10
        jump_to(7'd10, "t_jump");
        bus.imem_ack = 1'b0; stall = 1'b1;
        tick();
        check("t_wait_req", 32'(bus.fetch_req), 32'd1);
        bus.imem_ack = 1'b1;
        tick();
        expect_deliver("t", 7'd10);
        check("t_req_low", 32'(bus.fetch_req), 32'd0);
        bus.imem_ack = 1'b0;
        tick();
        check("t_req_low2", 32'(bus.fetch_req), 32'd0);
        check("t_valid_low", 32'(bus.instr_valid), 32'd0);
        stall = 1'b0;
        tick();
        check("t_resume_req", 32'(bus.fetch_req), 32'd1);
        check("t_resume_addr", 32'(bus.fetch_addr), 32'd11);

        // halt mid-request at pc=6
        jump_to(7'd6, "h_jump");
        bus.imem_ack = 1'b0; halt = 1'b1;
        tick();
        check("h_wait_req", 32'(bus.fetch_req), 32'd1);
        bus.imem_ack = 1'b1;
        tick();
        expect_deliver("h", 7'd6);
        check("h_halted", 32'(halted), 32'd1);
        check("h_req", 32'(bus.fetch_req), 32'd0);
        halt = 1'b0; jump = 1'b1; jump_target = 7'd30; branch_taken = 1'b1; branch_target = 7'd33;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("h_stay_halted", 32'(halted), 32'd1);
            check("h_stay_req", 32'(bus.fetch_req), 32'd0);
            check("h_stay_addr", 32'(bus.fetch_addr), 32'd7);
            check("h_stay_valid", 32'(bus.instr_valid), 32'd0);
        end
        clear_redirect();
        rst = 1'b1;
        #1;
        check("r_halted", 32'(halted), 32'd0);
        check("r_addr", 32'(bus.fetch_addr), 32'd0);
        check("r_req", 32'(bus.fetch_req), 32'd0);
        tick();
        rst = 1'b0; bus.imem_ack = 1'b1;
        tick();
        check("r_restart_addr", 32'(bus.fetch_addr), 32'd0);
        check("r_restart_req", 32'(bus.fetch_req), 32'd1);
        tick();
        expect_deliver("r", 7'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
